// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one result bit per clock.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST    = CNT_WIDTH'(W - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FINISH
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [2*W-1:0]         r_acc;
    logic [W-1:0]           r_opb;
    logic                   r_is_div;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_busy;
    logic                   r_done;
    logic [W-1:0]           r_hi;
    logic [W-1:0]           r_lo;

    // Request decode and operand magnitudes
    logic                   w_signed;
    logic                   w_div_op;
    logic                   w_rs_neg;
    logic                   w_rt_neg;
    logic                   w_rt_zero;
    logic [W-1:0]           w_rs_mag;
    logic [W-1:0]           w_rt_mag;

    assign w_signed  = (op == OP_MULT) || (op == OP_DIV);
    assign w_div_op  = (op == OP_DIV) || (op == OP_DIVU);
    assign w_rs_neg  = w_signed & rs[W-1];
    assign w_rt_neg  = w_signed & rt[W-1];
    assign w_rt_zero = (rt == '0);
    assign w_rs_mag  = w_rs_neg ? -rs : rs;
    assign w_rt_mag  = w_rt_neg ? -rt : rt;

    // Multiply step: acc = {partial product, remaining multiplier bits}
    logic [W-1:0]           w_mul_add;
    logic [W:0]             w_mul_sum;
    logic [2*W-1:0]         w_mul_next;

    assign w_mul_add  = r_acc[0] ? r_opb : '0;
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, w_mul_add};
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Divide step: acc = {partial remainder, dividend/quotient bits}
    logic [W:0]             w_div_trial;
    logic [2*W-1:0]         w_div_next;

    assign w_div_trial = r_acc[2*W-1:W-1] - {1'b0, r_opb};
    assign w_div_next  = w_div_trial[W] ? {r_acc[2*W-2:0], 1'b0}
                                        : {w_div_trial[W-1:0], r_acc[W-2:0], 1'b1};

    // Sign fixup applied on the way into HI/LO
    logic [W-1:0]           w_quot;
    logic [W-1:0]           w_rem;
    logic [2*W-1:0]         w_prod_fix;
    logic [W-1:0]           w_quot_fix;
    logic [W-1:0]           w_rem_fix;

    assign w_quot     = r_acc[W-1:0];
    assign w_rem      = r_acc[2*W-1:W];
    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quot_fix = r_neg_q ? -w_quot : w_quot;
    assign w_rem_fix  = r_neg_r ? -w_rem : w_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        unique case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_state  <= S_CALC;
                                r_busy   <= 1'b1;
                                r_cnt    <= '0;
                                r_is_div <= w_div_op;
                                if (w_div_op) begin
                                    r_acc   <= {{W{1'b0}}, w_rs_mag};
                                    r_opb   <= w_rt_mag;
                                    // Divide by zero keeps the all-ones quotient unnegated
                                    r_neg_q <= (w_rs_neg ^ w_rt_neg) & ~w_rt_zero;
                                    r_neg_r <= w_rs_neg;
                                end else begin
                                    r_acc   <= {{W{1'b0}}, w_rt_mag};
                                    r_opb   <= w_rs_mag;
                                    r_neg_q <= w_rs_neg ^ w_rt_neg;
                                    r_neg_r <= 1'b0;
                                end
                            end
                            OP_MTHI: r_hi <= rs;
                            OP_MTLO: r_lo <= rs;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + CNT_ONE;
                        if (r_cnt == LAST) r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*W-1:W];
                            r_lo <= w_prod_fix[W-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: scoreboard of expected {hi,lo},
// popped and compared on each done pulse.
module tb_mult_div_unit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] rs    = '0;
    logic [31:0] rt    = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .flush (flush),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent reference: plain SV arithmetic with the special cases spelled out
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sbv;
        longint unsigned ua, ub;
        int              qa, qb;
        case (o)
            3'd0: begin sa = longint'($signed(a)); sbv = longint'($signed(b)); return 64'(sa * sbv); end
            3'd1: begin ua = 64'(a); ub = 64'(b); return ua * ub; end
            3'd2: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                qa = $signed(a); qb = $signed(b);
                return {32'(qa % qb), 32'(qa / qb)};
            end
            3'd3: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Called at a negedge; the next posedge samples the request.
    task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs = a; rt = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the negedge after acceptance (lat=1); bounded wait for done.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 1; bcnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [63:0] e;
        chk({tag, " sb nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " hi"}, 64'(hi), 64'(e[63:32]));
            chk({tag, " lo"}, 64'(lo), 64'(e[31:0]));
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] e, input string tag);
        int lat, bc;
        sb.push_back(e);
        send(o, a, b);
        wait_done(lat, bc);
        chk({tag, " latency"}, 64'(lat - 1), 64'd33);
        chk({tag, " busy cycles"}, 64'(bc), 64'd33);
        chk({tag, " busy at done"}, 64'(busy), 64'd0);
        pop_check(tag);
        @(negedge clk);
        chk({tag, " done width"}, 64'(done), 64'd0);
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    initial begin
        int   lat, bc, n;
        logic [63:0] e2;
        vec_t vt[$];

        // Reset state
        @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(3'd0, 32'hFFFFFFFD, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFEB}, "mult -3*7");
        run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, "multu max*max");
        run(3'd2, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, "div -7/2");
        run(3'd3, 32'd100, 32'd0, {32'd100, 32'hFFFFFFFF}, "divu by zero");
        run(3'd2, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, "div overflow");
        run(3'd2, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, "div neg by zero");

        // MTHI/MTLO, then flush mid-CALC
        send(3'd4, 32'h11, 32'h0);
        chk("mthi hi", 64'(hi), 64'h11);
        chk("mthi busy", 64'(busy), 64'd0);
        send(3'd5, 32'h22, 32'h0);
        chk("mtlo lo", 64'(lo), 64'h22);
        send(3'd3, 32'd1000, 32'd7);
        chk("flush busy1", 64'(busy), 64'd1);
        op = 3'd4; rs = 32'hDEAD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("flush busy10", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush done", 64'(done), 64'd0);
        chk("flush hi", 64'(hi), 64'h11);
        chk("flush lo", 64'(lo), 64'h22);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        chk("flush no done", 64'(n), 64'd0);
        chk("mthi while busy ignored", 64'(hi), 64'h11);

        // Back-to-back: second start during done cycle
        e2 = model(3'd0, 32'h12345678, 32'h9ABCDEF0);
        sb.push_back({32'hFFFFFFFF, 32'hFFFFFFF4});
        sb.push_back(e2);
        send(3'd0, 32'd6, 32'hFFFFFFFE);
        wait_done(lat, bc);
        chk("b2b first latency", 64'(lat - 1), 64'd33);
        pop_check("b2b first");
        send(3'd0, 32'h12345678, 32'h9ABCDEF0);
        wait_done(lat, bc);
        chk("b2b done gap", 64'(lat), 64'd34);
        pop_check("b2b second");
        @(negedge clk);

        // start with flush in IDLE is dropped
        op = 3'd2; rs = 32'd10; rt = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        op = 3'd4; rs = 32'h77;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("start+flush busy", 64'(busy), 64'd0);
        chk("start+flush hi", 64'(hi), 64'(e2[63:32]));
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        chk("start+flush no done", 64'(n), 64'd0);

        // Mixed sign / random vectors against the model
        vt.push_back('{3'd2, 32'd7, 32'hFFFFFFFE});
        vt.push_back('{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE});
        vt.push_back('{3'd0, 32'h80000000, 32'h80000000});
        vt.push_back('{3'd3, 32'hFFFFFFFF, 32'd3});
        for (int i = 0; i < 4; i++)
            vt.push_back('{3'($urandom_range(0, 3)), $urandom, $urandom});
        foreach (vt[i])
            run(vt[i].o, vt[i].a, vt[i].b, model(vt[i].o, vt[i].a, vt[i].b), $sformatf("vec%0d", i));

        // Async reset mid-CALC
        send(3'd4, 32'hAAAA5555, 32'h0);
        send(3'd5, 32'h5555AAAA, 32'h0);
        send(3'd1, 32'd9, 32'd11);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst done", 64'(done), 64'd0);
        chk("async rst hi", 64'(hi), 64'd0);
        chk("async rst lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        chk("rst abandon no done", 64'(n), 64'd0);
        run(3'd1, 32'd3, 32'd5, {32'd0, 32'd15}, "multu 3*5");

        chk("sb drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
